// File: rtl/seq_det_pkg.sv
// Shared types and defaults for the 3-bit symbol sequence detector.
package seq_det_pkg;
  localparam int DEF_SYM_W   = 3;
  localparam int DEF_SEQ_LEN = 8;
  localparam int DEF_CNT_W   = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Slot 0 (oldest symbol) sits in the least significant bits.
  localparam logic [DEF_SEQ_LEN*DEF_SYM_W-1:0] DEFAULT_PATTERN =
    {3'b101, 3'b011, 3'b110, 3'b110, 3'b000, 3'b110, 3'b101, 3'b001};
endpackage

// File: rtl/seq_match_window.sv
// Symbol shift window with saturating fill count and full-width pattern compare.
module seq_match_window #(
  parameter int SYM_W   = 3,
  parameter int SEQ_LEN = 8
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            shift_en,
  input  logic                            clear,
  input  logic [SYM_W-1:0]                sym_in,
  input  logic [SEQ_LEN-1:0][SYM_W-1:0]   pattern,
  output logic                            hit
);
  localparam int FW = $clog2(SEQ_LEN + 1);

  logic [SEQ_LEN-1:0][SYM_W-1:0] win_q, win_d;
  logic [FW-1:0]                 fill_q, fill_d, fill_inc;

  always_comb begin
    win_d    = win_q;
    fill_inc = fill_q;
    if (shift_en) begin
      win_d    = {sym_in, win_q[SEQ_LEN-1:1]};
      fill_inc = (fill_q == FW'(SEQ_LEN)) ? fill_q : fill_q + 1'b1;
    end
  end

  // Hit is judged on the post-shift window so the pulse can register on this edge.
  assign hit    = shift_en && (fill_inc == FW'(SEQ_LEN)) && (win_d == pattern);
  assign fill_d = clear ? '0 : fill_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      win_q  <= '0;
      fill_q <= '0;
    end else begin
      win_q  <= win_d;
      fill_q <= fill_d;
    end
  end
endmodule

// File: rtl/seq_detect_ctrl.sv
// Arm/disarm controller, match counter and symbol handshake around seq_match_window.
module seq_detect_ctrl
  import seq_det_pkg::*;
#(
  parameter int SYM_W   = DEF_SYM_W,
  parameter int SEQ_LEN = DEF_SEQ_LEN,
  parameter int CNT_W   = DEF_CNT_W
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       cfg_we,
  input  logic [$clog2(SEQ_LEN)-1:0] cfg_addr,
  input  logic [SYM_W-1:0]           cfg_data,
  input  logic                       start,
  input  logic                       overlap,
  input  logic [CNT_W-1:0]           target_count,
  input  logic                       abort,
  input  logic                       in_valid,
  input  logic [SYM_W-1:0]           in_data,
  output logic                       in_ready,
  output logic                       sequence_found,
  output logic [CNT_W-1:0]           match_count,
  output logic                       busy,
  output logic                       done
);
  state_e                        state_q, state_d;
  logic [SEQ_LEN-1:0][SYM_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d, cnt_inc, tgt_q, tgt_d;
  logic                          ovl_q, ovl_d, found_q, found_d;
  logic                          accept, arm, hit, clr;

  // abort drops a same-cycle symbol, so it gates the shift directly.
  assign accept  = (state_q == ST_ARMED) && in_valid && !abort;
  assign arm     = start && ((state_q == ST_IDLE) || ((state_q == ST_DONE) && !abort));
  assign clr     = arm || (hit && !ovl_q);
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;

  seq_match_window #(.SYM_W(SYM_W), .SEQ_LEN(SEQ_LEN)) u_win (
    .clk      (clk),
    .reset    (reset),
    .shift_en (accept),
    .clear    (clr),
    .sym_in   (in_data),
    .pattern  (pat_q),
    .hit      (hit)
  );

  always_comb begin
    state_d = state_q;
    pat_d   = pat_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    ovl_d   = ovl_q;
    found_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_we) pat_d[cfg_addr] = cfg_data;
      end
      ST_ARMED: begin
        if (abort) begin
          state_d = ST_IDLE;
        end else if (accept && hit) begin
          found_d = 1'b1;
          cnt_d   = cnt_inc;
          if ((tgt_q != '0) && (cnt_inc == tgt_q)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (abort) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (arm) begin
      state_d = ST_ARMED;
      tgt_d   = target_count;
      ovl_d   = overlap;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pat_q   <= '0;
      cnt_q   <= '0;
      tgt_q   <= '0;
      ovl_q   <= 1'b0;
      found_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pat_q   <= pat_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      ovl_q   <= ovl_d;
      found_q <= found_d;
    end
  end

  assign in_ready       = (state_q == ST_ARMED);
  assign busy           = (state_q == ST_ARMED);
  assign done           = (state_q == ST_DONE);
  assign sequence_found = found_q;
  assign match_count    = cnt_q;
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Directed plus random bench for seq_detect_ctrl against a queue-based reference model.
module tb_seq_detect_ctrl;
  localparam int SW = 3;
  localparam int SL = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset, cfg_we, start, overlap, abort, in_valid;
  logic [2:0]    cfg_addr;
  logic [SW-1:0] cfg_data, in_data;
  logic [CW-1:0] target_count, match_count;
  logic          in_ready, sequence_found, busy, done;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seq_detect_ctrl dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .start(start), .overlap(overlap), .target_count(target_count), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .sequence_found(sequence_found), .match_count(match_count), .busy(busy), .done(done)
  );

  // Reference model: mode 0 idle, 1 armed, 2 done; hist holds accepted symbols since last restart.
  int         m_mode;
  logic [2:0] m_pat [SL];
  logic [2:0] hist [$];
  int         m_cnt, m_tgt;
  bit         m_ovl, m_found;
  logic [2:0] defp [SL] = '{3'b001, 3'b101, 3'b110, 3'b000, 3'b110, 3'b110, 3'b011, 3'b101};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
    end
  endtask

  function automatic bit window_matches();
    if (hist.size() != SL) return 0;
    for (int i = 0; i < SL; i++) if (hist[i] != m_pat[i]) return 0;
    return 1;
  endfunction

  task automatic model_arm();
    m_mode = 1; m_tgt = int'(target_count); m_ovl = overlap; m_cnt = 0; hist.delete();
  endtask

  task automatic model_edge();
    m_found = 0;
    if (reset) begin
      m_mode = 0; m_cnt = 0; m_tgt = 0; m_ovl = 0; hist.delete();
      for (int i = 0; i < SL; i++) m_pat[i] = '0;
    end else begin
      case (m_mode)
        0: begin
          if (cfg_we) m_pat[cfg_addr] = cfg_data;
          if (start) model_arm();
        end
        1: begin
          if (abort) m_mode = 0;
          else if (in_valid) begin
            hist.push_back(in_data);
            if (hist.size() > SL) void'(hist.pop_front());
            if (window_matches()) begin
              m_found = 1;
              if (m_cnt < 65535) m_cnt++;
              if (!m_ovl) hist.delete();
              if (m_tgt != 0 && m_cnt == m_tgt) m_mode = 2;
            end
          end
        end
        default: begin
          if (abort) m_mode = 0;
          else if (start) model_arm();
        end
      endcase
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    chk("found", 32'(sequence_found), 32'(m_found));
    chk("count", 32'(match_count), 32'(m_cnt));
    chk("busy",  32'(busy),  32'(m_mode == 1));
    chk("done",  32'(done),  32'(m_mode == 2));
    chk("ready", 32'(in_ready), 32'(m_mode == 1));
  endtask

  task automatic quiet();
    reset = 0; cfg_we = 0; cfg_addr = 0; cfg_data = 0; start = 0; overlap = 0;
    target_count = 0; abort = 0; in_valid = 0; in_data = 0;
  endtask

  task automatic load(input logic [2:0] p [SL]);
    for (int i = 0; i < SL; i++) begin
      cfg_we = 1; cfg_addr = 3'(i); cfg_data = p[i]; tick();
    end
    cfg_we = 0;
  endtask

  task automatic arm(input bit ovl, input int tgt);
    start = 1; overlap = ovl; target_count = CW'(tgt); tick(); start = 0;
  endtask

  task automatic sym(input logic [2:0] s, input int maxgap);
    in_valid = 0;
    repeat ($urandom_range(maxgap)) tick();
    in_valid = 1; in_data = s; tick(); in_valid = 0;
  endtask

  task automatic send_pat(input logic [2:0] p [SL], input int maxgap);
    for (int i = 0; i < SL; i++) sym(p[i], maxgap);
  endtask

  initial begin
    logic [2:0] allp [SL];
    logic [2:0] bad [SL];
    int nxt;
    for (int i = 0; i < SL; i++) allp[i] = 3'b110;
    quiet();
    reset = 1; tick(); tick(); reset = 0;
    chk("rst_found", 32'(sequence_found), 0);
    chk("rst_busy", 32'(busy), 0);

    // 1: single match, back-to-back
    load(defp); arm(0, 0); send_pat(defp, 0);
    chk("t1_count", 32'(match_count), 1);
    chk("t1_busy", 32'(busy), 1);
    abort = 1; tick(); abort = 0;

    // 2: periodic pattern with and without overlap
    load(allp); arm(1, 0);
    for (int i = 0; i < 10; i++) sym(3'b110, 0);
    chk("t2_ovl_count", 32'(match_count), 3);
    abort = 1; tick(); abort = 0;
    arm(0, 0);
    for (int i = 0; i < 10; i++) sym(3'b110, 0);
    chk("t2_noovl_count", 32'(match_count), 1);
    abort = 1; tick(); abort = 0;

    // 3: target count with gaps, third copy refused
    load(defp); arm(0, 2);
    send_pat(defp, 3); send_pat(defp, 3);
    chk("t3_done", 32'(done), 1);
    send_pat(defp, 1);
    chk("t3_count", 32'(match_count), 2);
    chk("t3_ready", 32'(in_ready), 0);

    // 4: abort collides with the final symbol; cfg_we while armed is ignored
    arm(0, 0);
    for (int i = 0; i < SL - 1; i++) sym(defp[i], 1);
    in_valid = 1; in_data = defp[SL-1]; abort = 1; tick();
    in_valid = 0; abort = 0;
    chk("t4_busy", 32'(busy), 0);
    chk("t4_count", 32'(match_count), 0);
    arm(0, 0);
    cfg_we = 1; cfg_addr = 0; cfg_data = 3'b111; tick(); cfg_we = 0;
    send_pat(defp, 1);
    chk("t4_readback", 32'(match_count), 1);
    abort = 1; tick(); abort = 0;

    // 5: reset mid-pattern
    arm(0, 0);
    for (int i = 0; i < 5; i++) sym(defp[i], 0);
    reset = 1; tick(); reset = 0;
    chk("t5_busy", 32'(busy), 0);
    chk("t5_count", 32'(match_count), 0);
    load(defp); arm(0, 0);
    for (int i = 5; i < SL; i++) sym(defp[i], 0);
    send_pat(defp, 0);
    chk("t5_count_after", 32'(match_count), 1);
    abort = 1; tick(); abort = 0;

    // 6: corrupted copy then clean copy
    bad = defp; bad[4] = 3'b111;
    arm(0, 0); send_pat(bad, 1);
    chk("t6_bad", 32'(match_count), 0);
    send_pat(defp, 1);
    chk("t6_clean", 32'(match_count), 1);

    // Random traffic biased toward the loaded pattern
    nxt = 0;
    for (int c = 0; c < 3000; c++) begin
      quiet();
      reset    = ($urandom_range(299) == 0);
      start    = ($urandom_range(24) == 0);
      abort    = ($urandom_range(79) == 0);
      overlap  = 1'($urandom);
      target_count = CW'($urandom_range(3));
      cfg_we   = ($urandom_range(15) == 0);
      cfg_addr = 3'($urandom);
      cfg_data = ($urandom_range(3) == 0) ? 3'($urandom) : m_pat[cfg_addr];
      in_valid = ($urandom_range(9) < 7);
      if ($urandom_range(9) < 8) begin
        in_data = m_pat[nxt]; nxt = (nxt + 1) % SL;
      end else begin
        in_data = 3'($urandom);
      end
      if ($urandom_range(499) == 0) begin
        for (int i = 0; i < SL; i++) m_pat[i] = m_pat[i];
      end
      tick();
    end
    quiet();
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule

// File: doc/seq_detect_ctrl.md
Name: seq_detect_ctrl

Overview:
Controller and sequencer for the 3-bit-symbol sequence detector datapath. It holds a programmable 8-symbol pattern and arms or disarms detection on command. It gates the incoming symbol stream with a valid/ready handshake, counts matches, and stops after a programmed match count. It sits between the configuration master and the symbol source, and provides sequence_found plus status to software and monitors.

Parameters:
SYM_W, 3, symbol width in bits
SEQ_LEN, 8, pattern length in symbols
CNT_W, 16, width of match counter and target count

Ports:
clk  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
cfg_we  input  1  pattern slot write strobe; honoured only in IDLE
cfg_addr  input  3  pattern slot index; slot 0 is the oldest and first symbol
cfg_data  input  SYM_W  pattern symbol value
start  input  1  arm pulse; honoured in IDLE or DONE
overlap  input  1  sampled at start: 1 allows overlapping matches, 0 restarts the search after a match
target_count  input  CNT_W  sampled at start; 0 means unlimited
abort  input  1  return to IDLE from ARMED or DONE
in_valid  input  1  symbol present
in_data  input  SYM_W  symbol
in_ready  output  1  symbol accepted when in_valid and in_ready are both high
sequence_found  output  1  one-cycle match pulse
match_count  output  CNT_W  matches since the last start
busy  output  1  high in ARMED
done  output  1  high in DONE

Behaviour:
- Reset (synchronous, active-high):
  - state goes to IDLE.
  - Pattern registers clear to 0.
  - Window, fill count, match_count, target, overlap latch all clear to 0.
  - Outputs: in_ready=0, sequence_found=0, busy=0, done=0.
  - Reset overrides every other input, including mid-operation.
- States: IDLE, ARMED, DONE. Encoding is binary, and busy and done are decoded from state.
- IDLE:
  - cfg_we writes pattern[cfg_addr] <= cfg_data at the edge.
  - in_ready=0.
  - start moves to ARMED. On the same edge: target and overlap latch, match_count and fill clear.
  - A cfg_we in the same cycle as start is applied.
- ARMED:
  - in_ready=1 combinationally from state. cfg_we is ignored.
  - On each accepted symbol:
    - window shifts; the newest symbol enters position SEQ_LEN-1 and the oldest drops out.
    - fill <= min(fill+1, SEQ_LEN).
  - A match occurs when the post-shift fill equals SEQ_LEN and window[i]==pattern[i] for every i.
  - On a match, at the same edge:
    - sequence_found is registered high for exactly the next cycle.
    - match_count increments and saturates at all-ones.
    - If overlap=0, fill clears to 0.
  - Latency: sequence_found is high in the cycle after the handshake cycle of the final symbol.
  - If target != 0 and the incremented count equals target, move to DONE on the same edge. The pulse still fires.
  - Cycles with in_valid=0 leave window, fill and count unchanged. Gaps never break a match.
  - abort moves to IDLE and takes priority over a simultaneous accepted symbol: that symbol is dropped, with no match and no pulse. match_count is retained.
  - start is ignored.
- DONE:
  - in_ready=0 and done=1.
  - match_count and the pattern are held.
  - start re-arms exactly as from IDLE.
  - abort moves to IDLE. If abort and start are both high, abort wins.
- sequence_found is never high for two consecutive cycles unless consecutive accepted symbols each complete a match (overlap=1 with a periodic pattern).
- Width rule: the match compare covers the full SYM_W*SEQ_LEN bits. Symbols X or Z are not tolerated; the source guarantees known values when in_valid=1.

Decomposition:
- Package seq_det_pkg holds:
  - state enum (IDLE, ARMED, DONE)
  - SYM_W and SEQ_LEN defaults
  - default pattern constant 001,101,110,000,110,110,011,101
- One sub-module, seq_match_window, containing the shift window, fill counter and compare. Interface: shift_en, clear, sym_in, pattern vector → hit.
- The controller FSM, counter and handshake live in seq_detect_ctrl.

Test Plan:
1. Load the default pattern, start with overlap=0 and target=0, stream the 8 symbols back-to-back → one sequence_found pulse one cycle after the 8th handshake; match_count=1; busy stays 1.
2. Pattern all 110, overlap=1, stream ten 110 symbols → pulses after symbols 8, 9 and 10; match_count=3. Repeat with overlap=0 → one pulse; match_count=1.
3. Default pattern, target=2, stream the pattern twice with random in_valid gaps, then a third copy → done=1 after the 2nd pulse; in_ready=0; the third copy is not accepted; match_count=2.
4. Abort asserted together with the 8th symbol's handshake → no pulse; state IDLE; match_count=0 retained. cfg_we during ARMED leaves the pattern unchanged (readback via a subsequent match).
5. Synchronous reset asserted after 5 pattern symbols → all outputs 0 next cycle; pattern cleared. After re-load and start, a full copy yields exactly one match, with no carry-over of the partial window.
6. Corrupt symbol 5 (111 instead of 110), then a clean copy → no pulse for the corrupted copy and exactly one pulse for the clean copy.
